// File: rtl/rk_read_sequencer.sv
// Round-key read sequencer: waits for the key buffer to hold the needed keys, then issues one
// paced read per round in encrypt (rk0..rkN-1) or decrypt (rkN-1..rk0) order.
module rk_read_sequencer #(
    parameter int unsigned ROUND_NUM       = 32,
    parameter int unsigned ROUND_DELAY     = 4,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned ROUND_CNT_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_stall,
    input  logic                  i_key_0_ready,
    input  logic                  i_key_ready,
    input  logic                  i_in_valid,
    input  logic                  i_in_dec,
    output logic                  o_in_ready,
    output logic [ADDR_WIDTH-1:0] o_rk_addr,
    output logic                  o_rk_valid,
    output logic [ADDR_WIDTH-1:0] o_round_idx,
    output logic                  o_round_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_abort
);

    localparam logic [ADDR_WIDTH-1:0]      LAST_IDX = ADDR_WIDTH'(ROUND_NUM - 1);
    localparam logic [ROUND_CNT_WIDTH-1:0] LAST_CNT = ROUND_CNT_WIDTH'(ROUND_DELAY - 1);

    typedef enum logic [3:0] {
        StIdle    = 4'b0001,
        StWaitKey = 4'b0010,
        StRun     = 4'b0100,
        StDone    = 4'b1000
    } state_e;

    state_e                     r_state,     w_state_nxt;
    logic                       r_mode,      w_mode_nxt;
    logic [ADDR_WIDTH-1:0]      r_round_idx, w_round_idx_nxt;
    logic [ROUND_CNT_WIDTH-1:0] r_round_cnt, w_round_cnt_nxt;
    logic                       r_abort,     w_abort_nxt;
    logic                       r_key_seen,  w_key_seen_nxt;
    logic                       w_key_ok;

    assign w_key_ok = r_mode ? i_key_ready : i_key_0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_mode      <= 1'b0;
            r_round_idx <= '0;
            r_round_cnt <= '0;
            r_abort     <= 1'b0;
            r_key_seen  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_round_idx <= w_round_idx_nxt;
            r_round_cnt <= w_round_cnt_nxt;
            r_abort     <= w_abort_nxt;
            r_key_seen  <= w_key_seen_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_round_idx_nxt = r_round_idx;
        w_round_cnt_nxt = r_round_cnt;
        w_abort_nxt     = r_abort;
        w_key_seen_nxt  = r_key_seen;

        // Remembers that rk0 was present while waiting, so a later drop is a re-key, not a wait.
        if (r_state == StWaitKey && i_key_0_ready) begin
            w_key_seen_nxt = 1'b1;
        end

        if (!i_stall) begin
            w_abort_nxt = 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        w_mode_nxt     = i_in_dec;
                        w_key_seen_nxt = 1'b0;
                        w_state_nxt    = StWaitKey;
                    end
                end
                StWaitKey: begin
                    if (w_key_ok) begin
                        w_state_nxt     = StRun;
                        w_round_idx_nxt = '0;
                        w_round_cnt_nxt = '0;
                    end else if (!r_mode && r_key_seen && !i_key_0_ready) begin
                        w_abort_nxt = 1'b1;
                        w_state_nxt = StIdle;
                    end
                end
                StRun: begin
                    if (!i_key_0_ready) begin
                        w_abort_nxt     = 1'b1;
                        w_state_nxt     = StIdle;
                        w_round_idx_nxt = '0;
                        w_round_cnt_nxt = '0;
                    end else if (r_round_cnt == LAST_CNT) begin
                        w_round_cnt_nxt = '0;
                        if (r_round_idx == LAST_IDX) begin
                            w_state_nxt     = StDone;
                            w_round_idx_nxt = '0;
                        end else begin
                            w_round_idx_nxt = r_round_idx + ADDR_WIDTH'(1);
                        end
                    end else begin
                        w_round_cnt_nxt = r_round_cnt + ROUND_CNT_WIDTH'(1);
                    end
                end
                StDone: begin
                    w_state_nxt = StIdle;
                end
                default: begin
                    w_state_nxt     = StIdle;
                    w_round_idx_nxt = '0;
                    w_round_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_in_ready   = rst_n && (r_state == StIdle) && !i_stall;
        o_rk_valid   = (r_state == StRun) && (r_round_cnt == '0) && !i_stall;
        o_rk_addr    = '0;
        if (r_state == StRun) begin
            o_rk_addr = r_mode ? (LAST_IDX - r_round_idx) : r_round_idx;
        end
        o_round_idx  = r_round_idx;
        o_round_last = (r_state == StRun) && (r_round_idx == LAST_IDX);
        o_busy       = (r_state != StIdle);
        o_done       = (r_state == StDone);
        o_abort      = r_abort;
    end

endmodule
